cmd_stream_dma: RTL and testbench

// Transmitter end of the rasterizer command stream: fetches a command list from memory via
// an AXI4 read master and emits it as the 32-bit AXIS command stream consumed by s_cmd_axis_*.

---
 rtl/cmd_stream_dma_if.sv | 49 ++++
 rtl/cmd_stream_dma.sv | 168 ++++++++++++++++
 tb/tb_cmd_stream_dma.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cmd_stream_dma_if.sv
// AXI4 read-address/read-data channels plus the AXIS command stream of the command DMA.
// master = DMA side, slave = memory + stream sink side.
interface cmd_stream_dma_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int ID_WIDTH   = 8
);
  logic [ID_WIDTH-1:0]   m_axi_arid;
  logic [ADDR_WIDTH-1:0] m_axi_araddr;
  logic [7:0]            m_axi_arlen;
  logic [2:0]            m_axi_arsize;
  logic [1:0]            m_axi_arburst;
  logic                  m_axi_arlock;
  logic [3:0]            m_axi_arcache;
  logic [2:0]            m_axi_arprot;
  logic                  m_axi_arvalid;
  logic                  m_axi_arready;

  logic [ID_WIDTH-1:0]   m_axi_rid;
  logic [31:0]           m_axi_rdata;
  logic [1:0]            m_axi_rresp;
  logic                  m_axi_rlast;
  logic                  m_axi_rvalid;
  logic                  m_axi_rready;

  logic                  m_cmd_axis_tvalid;
  logic                  m_cmd_axis_tready;
  logic                  m_cmd_axis_tlast;
  logic [31:0]           m_cmd_axis_tdata;

  modport master (
    output m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
    output m_axi_arlock, m_axi_arcache, m_axi_arprot, m_axi_arvalid,
    input  m_axi_arready,
    input  m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
    output m_axi_rready,
    output m_cmd_axis_tvalid, m_cmd_axis_tlast, m_cmd_axis_tdata,
    input  m_cmd_axis_tready
  );

  modport slave (
    input  m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
    input  m_axi_arlock, m_axi_arcache, m_axi_arprot, m_axi_arvalid,
    output m_axi_arready,
    output m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
    input  m_axi_rready,
    input  m_cmd_axis_tvalid, m_cmd_axis_tlast, m_cmd_axis_tdata,
    output m_cmd_axis_tready
  );
endinterface

// File: rtl/cmd_stream_dma.sv
// Command-list DMA: AXI4 INCR read bursts (<= BURST_LEN, never crossing 4 KiB) into a FIFO, out as AXIS.
// Latency: R beat -> tvalid 1 cycle (registered FIFO, no bypass); done pulses 1 cycle after last word.
// Backpressure: tready stalls drain; AR issue waits for FIFO credit so rready stays high.
module cmd_stream_dma #(
  parameter int ADDR_WIDTH = 32,
  parameter int ID_WIDTH   = 8,
  parameter int LEN_WIDTH  = 24,
  parameter int BURST_LEN  = 16,
  parameter int FIFO_DEPTH = 64
) (
  input  logic                  aclk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [LEN_WIDTH-1:0]  length_words,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  cmd_stream_dma_if.master      bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = CW + 10;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LEN_WIDTH-1:0]  remaining_q;
  logic [LEN_WIDTH-1:0]  len_q;
  logic [LEN_WIDTH-1:0]  out_cnt;
  logic [CW-1:0]         outstanding;
  logic [8:0]            beats_q;
  logic                  arvalid_q;
  logic [ADDR_WIDTH-1:0] araddr_q;
  logic [7:0]            arlen_q;

  logic [31:0]           mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [CW-1:0]         count;

  logic                  push;
  logic                  pop;
  logic                  tvalid_i;
  logic                  tlast_i;
  logic [12:0]           page_words;
  logic [8:0]            beats;
  logic                  credit_ok;
  logic                  issue;
  logic                  unused_r;

  assign push     = bus.m_axi_rvalid;
  assign tvalid_i = (count != '0);
  assign pop      = tvalid_i && bus.m_cmd_axis_tready;
  // tlast comes from the output word counter; rlast is meaningless across bursts
  assign tlast_i  = tvalid_i && (out_cnt == len_q - LEN_WIDTH'(1));
  assign unused_r = ^{bus.m_axi_rid, bus.m_axi_rlast};

  always_comb begin
    page_words = (13'h1000 - {1'b0, addr_q[11:0]}) >> 2;
    beats      = 9'(BURST_LEN);
    if ({4'b0, beats} > page_words) beats = page_words[8:0];
    if (LEN_WIDTH'(beats) > remaining_q) beats = remaining_q[8:0];
    // count + outstanding covers every word that can still land in the FIFO
    credit_ok = (SW'(count) + SW'(outstanding) + SW'(beats)) <= SW'(FIFO_DEPTH);
  end

  assign issue = (state == ISSUE) && !arvalid_q && credit_ok;

  always_ff @(posedge aclk) begin
    if (reset) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      addr_q      <= '0;
      remaining_q <= '0;
      len_q       <= '0;
      out_cnt     <= '0;
      outstanding <= '0;
      beats_q     <= '0;
      arvalid_q   <= 1'b0;
      araddr_q    <= '0;
      arlen_q     <= '0;
    end else begin
      done <= 1'b0;
      if (push && bus.m_axi_rresp != 2'b00) error <= 1'b1;
      // credit is reserved when arvalid rises and returned one beat at a time
      outstanding <= outstanding + (issue ? CW'(beats) : CW'(0))
                     - ((push && outstanding != '0) ? CW'(1) : CW'(0));
      if (pop) out_cnt <= out_cnt + LEN_WIDTH'(1);

      case (state)
        IDLE: begin
          if (start) begin
            addr_q      <= start_addr;
            remaining_q <= length_words;
            len_q       <= length_words;
            out_cnt     <= '0;
            error       <= 1'b0;
            if (length_words == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= ISSUE;
              busy  <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (arvalid_q) begin
            if (bus.m_axi_arready) begin
              arvalid_q   <= 1'b0;
              addr_q      <= addr_q + ADDR_WIDTH'({beats_q, 2'b00});
              remaining_q <= remaining_q - LEN_WIDTH'(beats_q);
              if (remaining_q == LEN_WIDTH'(beats_q)) state <= DRAIN;
            end
          end else if (credit_ok) begin
            arvalid_q <= 1'b1;
            araddr_q  <= addr_q;
            arlen_q   <= 8'(beats - 9'd1);
            beats_q   <= beats;
          end
        end
        DRAIN: begin
          if (pop && tlast_i) begin
            state <= DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge aclk) begin
    if (push) mem[wr_ptr] <= bus.m_axi_rdata;
  end

  always_ff @(posedge aclk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign bus.m_axi_arid      = ID_WIDTH'(0);
  assign bus.m_axi_araddr    = araddr_q;
  assign bus.m_axi_arlen     = arlen_q;
  assign bus.m_axi_arsize    = 3'b010;
  assign bus.m_axi_arburst   = 2'b01;
  assign bus.m_axi_arlock    = 1'b0;
  assign bus.m_axi_arcache   = 4'b0011;
  assign bus.m_axi_arprot    = 3'b000;
  assign bus.m_axi_arvalid   = arvalid_q;
  assign bus.m_axi_rready    = 1'b1;
  assign bus.m_cmd_axis_tvalid = tvalid_i;
  assign bus.m_cmd_axis_tlast  = tlast_i;
  assign bus.m_cmd_axis_tdata  = mem[rd_ptr];
endmodule

// File: tb/tb_cmd_stream_dma.sv
// Bench for cmd_stream_dma: randomized AXI read slave and AXIS sink around directed transfers,
// expected AR bursts and stream words queued at stimulus time and popped as the DUT produces them.
module tb_cmd_stream_dma;
  localparam int AW = 32;
  localparam int LW = 24;

  typedef struct { logic [31:0] addr; logic [7:0] len; } ar_t;
  typedef struct { logic [31:0] data; logic last; } w_t;

  logic          aclk;
  logic          reset;
  logic          start;
  logic [AW-1:0] start_addr;
  logic [LW-1:0] length_words;
  logic          busy;
  logic          done;
  logic          error;

  int  checks = 0;
  int  errors = 0;
  bit  stall;
  int  err_beat;
  int  beat_cnt;
  int  ar_total;
  int  words_out;
  int  max_inflight;
  ar_t exp_ar[$];
  w_t  exp_w[$];

  cmd_stream_dma_if #(.ADDR_WIDTH(AW), .ID_WIDTH(8)) bus ();

  cmd_stream_dma #(
    .ADDR_WIDTH(AW), .ID_WIDTH(8), .LEN_WIDTH(LW), .BURST_LEN(16), .FIFO_DEPTH(64)
  ) dut (
    .aclk(aclk), .reset(reset), .start(start), .start_addr(start_addr),
    .length_words(length_words), .busy(busy), .done(done), .error(error), .bus(bus)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h0F0F_0000;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_ar(input logic [31:0] a, input logic [7:0] l);
    ar_t e;
    e.addr = a;
    e.len  = l;
    exp_ar.push_back(e);
  endtask

  task automatic push_words(input logic [31:0] a, input int len);
    w_t w;
    for (int i = 0; i < len; i++) begin
      w.data = word_at(a + 32'(4 * i));
      w.last = (i == len - 1);
      exp_w.push_back(w);
    end
  endtask

  task automatic run_xfer(input logic [31:0] a, input int len, input int err_idx,
                          input bit exp_err, input int stall_cyc, input bit glitch);
    int cyc;
    push_words(a, len);
    err_beat = err_idx;
    beat_cnt = 0;
    stall    = (stall_cyc > 0);
    @(posedge aclk); #1;
    start = 1'b1; start_addr = a; length_words = LW'(len);
    @(posedge aclk); #1;
    start = 1'b0; start_addr = 32'hDEAD_BEE0; length_words = LW'(7);
    cyc = 0;
    do begin
      @(negedge aclk);
      cyc++;
      if (cyc == 1 && len > 0) chk("busy_after_start", busy, 1);
      if (stall_cyc > 0 && cyc == stall_cyc) begin
        chk("stall_inflight", ar_total - words_out, 64);
        chk("stall_tvalid", bus.m_cmd_axis_tvalid, 1);
        stall = 1'b0;
      end
      if (glitch && cyc == 5) begin
        @(posedge aclk); #1;
        start = 1'b1; start_addr = 32'h5000; length_words = LW'(3);
        @(posedge aclk); #1;
        start = 1'b0;
      end
    end while (!done && cyc < 4000);
    chk("done_pulse", done, 1);
    if (len == 0) chk("zero_len_latency", cyc, 1);
    chk("busy_at_done", busy, 0);
    chk("error_at_done", error, exp_err);
    @(negedge aclk);
    chk("done_width", done, 0);
    chk("words_left", exp_w.size(), 0);
    chk("ar_left", exp_ar.size(), 0);
  endtask

  // AXI read slave: random arready, random gaps between R beats
  initial begin : axi_slave
    ar_t         pend[$];
    ar_t         e;
    ar_t         p;
    logic [31:0] cur_addr;
    int          cur_left;
    bit          clr;
    bit          r_hs;
    bit          lat_pend;
    cur_addr = '0;
    cur_left = 0;
    lat_pend = 1'b0;
    bus.m_axi_arready = 1'b0;
    bus.m_axi_rvalid  = 1'b0;
    bus.m_axi_rdata   = '0;
    bus.m_axi_rresp   = 2'b00;
    bus.m_axi_rlast   = 1'b0;
    bus.m_axi_rid     = '0;
    forever begin
      @(negedge aclk);
      clr  = reset;
      r_hs = 1'b0;
      if (lat_pend) begin
        chk("first_beat_latency", bus.m_cmd_axis_tvalid, 1);
        lat_pend = 1'b0;
      end
      if (!clr) begin
        if (bus.m_axi_arvalid && bus.m_axi_arready) begin
          chk("ar_expected", exp_ar.size() > 0, 1);
          chk("ar_fixed", {bus.m_axi_arid, bus.m_axi_arsize, bus.m_axi_arburst, bus.m_axi_arlock,
                           bus.m_axi_arcache, bus.m_axi_arprot},
              {8'h00, 3'b010, 2'b01, 1'b0, 4'b0011, 3'b000});
          if (exp_ar.size() > 0) begin
            e = exp_ar.pop_front();
            chk("ar_addr", bus.m_axi_araddr, e.addr);
            chk("ar_len", bus.m_axi_arlen, e.len);
          end
          p.addr = bus.m_axi_araddr;
          p.len  = bus.m_axi_arlen;
          pend.push_back(p);
          ar_total += int'(bus.m_axi_arlen) + 1;
          if (ar_total - words_out > max_inflight) max_inflight = ar_total - words_out;
        end
        if (bus.m_axi_rvalid) begin
          r_hs = 1'b1;
          chk("rready_high", bus.m_axi_rready, 1);
          if (beat_cnt == 0) begin
            chk("no_bypass", bus.m_cmd_axis_tvalid, 0);
            lat_pend = 1'b1;
          end
        end
      end
      @(posedge aclk); #1;
      if (clr) begin
        pend.delete();
        cur_left = 0;
        lat_pend = 1'b0;
        beat_cnt = 0;
      end else if (r_hs) begin
        cur_addr += 32'd4;
        cur_left--;
        beat_cnt++;
      end
      if (cur_left == 0 && pend.size() > 0) begin
        p = pend.pop_front();
        cur_addr = p.addr;
        cur_left = int'(p.len) + 1;
      end
      bus.m_axi_arready = !clr && ($urandom_range(0, 3) != 0);
      if (!clr && cur_left > 0 && $urandom_range(0, 3) != 0) begin
        bus.m_axi_rvalid = 1'b1;
        bus.m_axi_rdata  = word_at(cur_addr);
        bus.m_axi_rresp  = (beat_cnt == err_beat) ? 2'b10 : 2'b00;
        bus.m_axi_rlast  = (cur_left == 1);
      end else begin
        bus.m_axi_rvalid = 1'b0;
        bus.m_axi_rresp  = 2'b00;
        bus.m_axi_rlast  = 1'b0;
      end
    end
  end

  // AXIS sink: scoreboard compare on every accepted word
  initial begin : axis_sink
    w_t w;
    bus.m_cmd_axis_tready = 1'b0;
    forever begin
      @(negedge aclk);
      if (!reset && bus.m_cmd_axis_tvalid && bus.m_cmd_axis_tready) begin
        words_out++;
        chk("axis_expected", exp_w.size() > 0, 1);
        if (exp_w.size() > 0) begin
          w = exp_w.pop_front();
          chk("tdata", bus.m_cmd_axis_tdata, w.data);
          chk("tlast", bus.m_cmd_axis_tlast, w.last);
        end
      end
      @(posedge aclk); #1;
      bus.m_cmd_axis_tready = !stall && ($urandom_range(0, 3) != 0);
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    reset = 1'b1; start = 1'b0; start_addr = '0; length_words = '0;
    stall = 1'b0; err_beat = -1; beat_cnt = 0;
    ar_total = 0; words_out = 0; max_inflight = 0;
    repeat (4) @(posedge aclk);
    #1 reset = 1'b0;
    @(negedge aclk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_arvalid", bus.m_axi_arvalid, 0);
    chk("rst_tvalid", bus.m_cmd_axis_tvalid, 0);
    chk("rst_tlast", bus.m_cmd_axis_tlast, 0);
    chk("rst_rready", bus.m_axi_rready, 1);

    push_ar(32'h1000, 8'd4);
    run_xfer(32'h1000, 5, -1, 1'b0, 0, 1'b0);

    push_ar(32'h000, 8'd15); push_ar(32'h040, 8'd15); push_ar(32'h080, 8'd7);
    run_xfer(32'h0, 40, -1, 1'b0, 0, 1'b1);

    push_ar(32'h0FF8, 8'd1); push_ar(32'h1000, 8'd1);
    run_xfer(32'h0FF8, 4, -1, 1'b0, 0, 1'b0);

    for (int i = 0; i < 12; i++) push_ar(32'(64 * i), 8'd15);
    push_ar(32'h300, 8'd7);
    run_xfer(32'h0, 200, -1, 1'b0, 100, 1'b0);

    push_ar(32'h2000, 8'd7);
    run_xfer(32'h2000, 8, 2, 1'b1, 0, 1'b0);
    repeat (3) @(negedge aclk);
    chk("error_sticky", error, 1);

    run_xfer(32'h3000, 0, -1, 1'b0, 0, 1'b0);

    // reset in the middle of a 100-word transfer
    for (int i = 0; i < 6; i++) push_ar(32'h4000 + 32'(64 * i), 8'd15);
    push_ar(32'h4180, 8'd3);
    push_words(32'h4000, 100);
    err_beat = -1; beat_cnt = 0;
    @(posedge aclk); #1;
    start = 1'b1; start_addr = 32'h4000; length_words = LW'(100);
    @(posedge aclk); #1;
    start = 1'b0;
    repeat (20) @(posedge aclk);
    #1 reset = 1'b1;
    @(posedge aclk);
    @(negedge aclk);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_error", error, 0);
    chk("mid_rst_arvalid", bus.m_axi_arvalid, 0);
    chk("mid_rst_tvalid", bus.m_cmd_axis_tvalid, 0);
    chk("mid_rst_tlast", bus.m_cmd_axis_tlast, 0);
    chk("mid_rst_rready", bus.m_axi_rready, 1);
    @(posedge aclk); #1;
    reset = 1'b0;
    exp_ar.delete();
    exp_w.delete();
    ar_total = 0;
    words_out = 0;

    push_ar(32'h0FF0, 8'd3); push_ar(32'h1000, 8'd1);
    run_xfer(32'h0FF0, 6, -1, 1'b0, 0, 1'b0);

    chk("credit_max", max_inflight <= 64, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
